// File: rtl/lstm_pkg.sv
// lstm_pkg: shared Q-format definitions for the LSTM cell-update pipeline.
//   q_t               signed Q(DATA_W-FRAC).FRAC word
//   ONE, HALF         1.0 and 0.5 in Q format
//   DATA_MAX/DATA_MIN saturation bounds of q_t
//   act_mode_e        activation selector for lstm_act_pwl
//   sat_mul_q         full-precision product, floor shift by FRAC, saturate
//   sat_add_q         saturating signed add
package lstm_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC   = 16;

    typedef logic signed [DATA_W-1:0] q_t;

    typedef enum logic {
        ACT_SIG  = 1'b0,
        ACT_TANH = 1'b1
    } act_mode_e;

    localparam q_t ONE      = q_t'(1 << FRAC);
    localparam q_t HALF     = q_t'(1 << (FRAC - 1));
    localparam q_t DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam q_t DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic q_t sat_mul_q(input q_t a, input q_t b);
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        // arithmetic shift gives floor rounding for negative products
        p = p >>> FRAC;
        if (p > (2*DATA_W)'(DATA_MAX)) return DATA_MAX;
        if (p < (2*DATA_W)'(DATA_MIN)) return DATA_MIN;
        return p[DATA_W-1:0];
    endfunction

    function automatic q_t sat_add_q(input q_t a, input q_t b);
        logic signed [DATA_W:0] s;
        s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
        if (s > (DATA_W+1)'(DATA_MAX)) return DATA_MAX;
        if (s < (DATA_W+1)'(DATA_MIN)) return DATA_MIN;
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/lstm_act_pwl.sv
// lstm_act_pwl: combinational piecewise-linear activation.
//   mode  ACT_SIG : y = clamp((x >>> 2) + 0.5, 0, 1.0)
//         ACT_TANH: y = clamp(x, -1.0, 1.0)
//   x     signed Q input
//   y     signed Q output
module lstm_act_pwl
    import lstm_pkg::*;
#(
    parameter int DATA_W = lstm_pkg::DATA_W,
    parameter int FRAC   = lstm_pkg::FRAC
)(
    input  act_mode_e                 mode,
    input  logic signed [DATA_W-1:0]  x,
    output logic signed [DATA_W-1:0]  y
);

    // one extra bit so the +0.5 offset can never wrap
    localparam logic signed [DATA_W:0] ONE_W     = {{(DATA_W-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [DATA_W:0] HALF_W    = {{(DATA_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [DATA_W:0] NEG_ONE_W = -ONE_W;

    logic signed [DATA_W:0] xw;
    logic signed [DATA_W:0] sig;

    always_comb begin
        xw  = {x[DATA_W-1], x};
        sig = (xw >>> 2) + HALF_W;
        y   = '0;
        if (mode == ACT_SIG) begin
            if (sig[DATA_W])      y = '0;
            else if (sig > ONE_W) y = ONE_W[DATA_W-1:0];
            else                  y = sig[DATA_W-1:0];
        end else begin
            if (xw > ONE_W)          y = ONE_W[DATA_W-1:0];
            else if (xw < NEG_ONE_W) y = NEG_ONE_W[DATA_W-1:0];
            else                     y = x;
        end
    end

endmodule

// File: rtl/lstm_cell_update_pipe.sv
// lstm_cell_update_pipe: 4-stage pipelined LSTM cell/hidden update, LANES
// elements per beat, HIDDEN/LANES beats per hidden vector.
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_f/in_g/in_i/in_o/in_c_prev  per-lane gate pre-activations, c_{t-1}
//   in_last                        sender's end-of-vector marker (checked only)
//   out_valid/out_ready            output handshake
//   out_c, out_h, out_last         c_next, h_t, internally generated framing
//   seq_err                        sticky: in_last disagreed with beat count
// Stages: S1 activations, S2 products, S3 saturating add (c registered),
// S4 htanh(c) * o' onto out_h with c carried to out_c. A single global stall
// freezes every stage while the output beat is not taken.
module lstm_cell_update_pipe
    import lstm_pkg::*;
#(
    parameter int HIDDEN = 100,
    parameter int LANES  = 4,
    parameter int DATA_W = lstm_pkg::DATA_W,
    parameter int FRAC   = lstm_pkg::FRAC
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0][DATA_W-1:0]  in_f,
    input  logic [LANES-1:0][DATA_W-1:0]  in_g,
    input  logic [LANES-1:0][DATA_W-1:0]  in_i,
    input  logic [LANES-1:0][DATA_W-1:0]  in_o,
    input  logic [LANES-1:0][DATA_W-1:0]  in_c_prev,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0][DATA_W-1:0]  out_c,
    output logic [LANES-1:0][DATA_W-1:0]  out_h,
    output logic                          out_last,
    output logic                          seq_err
);

    localparam int STAGES = 4;
    localparam int BEATS  = HIDDEN / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    if (HIDDEN % LANES != 0) begin : g_chk_hidden
        $error("HIDDEN must be a multiple of LANES");
    end
    // arithmetic helpers live in the package at a fixed Q format
    if (DATA_W != lstm_pkg::DATA_W || FRAC != lstm_pkg::FRAC) begin : g_chk_q
        $error("DATA_W/FRAC must match lstm_pkg");
    end

    logic             stall, accept, is_last;
    logic [CNT_W-1:0] beat_cnt;
    logic [STAGES:1]  vld_pipe, last_pipe;

    vec_t f_act, i_act, g_act, o_act;
    vec_t fc_prod, ig_prod, c_sum, c_tanh, h_prod;
    vec_t s1_f, s1_i, s1_g, s1_o, s1_c;
    vec_t s2_fc, s2_ig, s2_o;
    vec_t s3_c, s3_o;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign is_last   = (beat_cnt == LAST_IDX);
    assign out_valid = vld_pipe[STAGES];
    assign out_last  = last_pipe[STAGES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lstm_act_pwl #(.DATA_W(DATA_W), .FRAC(FRAC)) u_act_f (.mode(ACT_SIG),  .x(in_f[l]), .y(f_act[l]));
        lstm_act_pwl #(.DATA_W(DATA_W), .FRAC(FRAC)) u_act_i (.mode(ACT_SIG),  .x(in_i[l]), .y(i_act[l]));
        lstm_act_pwl #(.DATA_W(DATA_W), .FRAC(FRAC)) u_act_g (.mode(ACT_TANH), .x(in_g[l]), .y(g_act[l]));
        lstm_act_pwl #(.DATA_W(DATA_W), .FRAC(FRAC)) u_act_o (.mode(ACT_SIG),  .x(in_o[l]), .y(o_act[l]));

        assign fc_prod[l] = sat_mul_q(q_t'(s1_f[l]), q_t'(s1_c[l]));
        assign ig_prod[l] = sat_mul_q(q_t'(s1_i[l]), q_t'(s1_g[l]));
        assign c_sum[l]   = sat_add_q(q_t'(s2_fc[l]), q_t'(s2_ig[l]));

        lstm_act_pwl #(.DATA_W(DATA_W), .FRAC(FRAC)) u_act_c (.mode(ACT_TANH), .x(s3_c[l]), .y(c_tanh[l]));

        assign h_prod[l]  = sat_mul_q(q_t'(s3_o[l]), q_t'(c_tanh[l]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_f      <= '0;
            s1_i      <= '0;
            s1_g      <= '0;
            s1_o      <= '0;
            s1_c      <= '0;
            s2_fc     <= '0;
            s2_ig     <= '0;
            s2_o      <= '0;
            s3_c      <= '0;
            s3_o      <= '0;
            out_c     <= '0;
            out_h     <= '0;
        end else if (!stall) begin
            // data registers load on bubbles too; vld_pipe qualifies them
            vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
            last_pipe <= {last_pipe[STAGES-1:1], accept && is_last};
            s1_f      <= f_act;
            s1_i      <= i_act;
            s1_g      <= g_act;
            s1_o      <= o_act;
            s1_c      <= in_c_prev;
            s2_fc     <= fc_prod;
            s2_ig     <= ig_prod;
            s2_o      <= s1_o;
            s3_c      <= c_sum;
            s3_o      <= s2_o;
            out_c     <= s3_c;
            out_h     <= h_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            seq_err  <= 1'b0;
        end else if (accept) begin
            beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
            if (in_last != is_last) seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lstm_cell_update_pipe.sv
module tb_lstm_cell_update_pipe;

    localparam int L = 4;
    typedef logic [L-1:0][31:0] vec_t;
    typedef struct packed { vec_t c; vec_t h; logic last; } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, seq_err;
    vec_t in_f, in_g, in_i, in_o, in_c_prev, out_c, out_h;

    lstm_cell_update_pipe #(.HIDDEN(8), .LANES(L), .DATA_W(32), .FRAC(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_g(in_g), .in_i(in_i), .in_o(in_o), .in_c_prev(in_c_prev),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_h(out_h), .out_last(out_last), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_fail = 0, n_last = 0, drv_cnt = 0, mcnt = 0;
    bit   mon_en = 1'b0, exp_seq_err = 1'b0, done = 1'b0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---- behavioural model: plain 64-bit integer arithmetic on Q16.16 ----
    function automatic longint sx(input logic [31:0] v);
        return longint'(signed'(v));
    endfunction
    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction
    function automatic longint hsig(input longint x);
        longint y = (x >>> 2) + 32768;
        if (y < 0) return 0;
        if (y > 65536) return 65536;
        return y;
    endfunction
    function automatic longint htanh(input longint x);
        if (x > 65536) return 65536;
        if (x < -65536) return -65536;
        return x;
    endfunction
    function automatic longint qmul(input longint a, input longint b);
        return sat32((a * b) >>> 16);
    endfunction
    function automatic logic [31:0] model_c(input logic [31:0] f, i, g, cp);
        longint c = sat32(qmul(hsig(sx(f)), sx(cp)) + qmul(hsig(sx(i)), htanh(sx(g))));
        return c[31:0];
    endfunction
    function automatic logic [31:0] model_h(input logic [31:0] o, c);
        longint h = qmul(hsig(sx(o)), htanh(sx(c)));
        return h[31:0];
    endfunction

    function automatic logic [31:0] rq();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
        endcase
    endfunction
    function automatic vec_t rv();
        vec_t v;
        for (int l = 0; l < L; l++) v[l] = rq();
        return v;
    endfunction
    function automatic vec_t sp(input logic [31:0] x);
        vec_t v;
        for (int l = 0; l < L; l++) v[l] = x;
        return v;
    endfunction

    // ---- compare process: every cycle, sampled at negedge ----
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            chk("seq_err", seq_err, exp_seq_err);
            if (out_valid) begin
                if (q.size() == 0) chk("spurious out_valid", out_valid, 0);
                else begin
                    chk("out_c", out_c, q[0].c);
                    chk("out_h", out_h, q[0].h);
                    chk("out_last", out_last, q[0].last);
                    if (out_ready && !rst) begin
                        if (out_last) n_last++;
                        void'(q.pop_front());
                    end
                end
            end
            if (rst) begin
                q.delete();
                mcnt = 0;
                exp_seq_err = 1'b0;
            end else if (in_valid && in_ready) begin
                for (int l = 0; l < L; l++) begin
                    e.c[l] = model_c(in_f[l], in_i[l], in_g[l], in_c_prev[l]);
                    e.h[l] = model_h(in_o[l], e.c[l]);
                end
                e.last = (mcnt == 1);
                if (in_last != (mcnt == 1)) exp_seq_err = 1'b1;
                mcnt = (mcnt + 1) % 2;
                q.push_back(e);
            end
        end
    end

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_beat(input vec_t f, i, g, o, c, input bit bad);
        bit acc = 1'b0;
        in_f = f; in_i = i; in_g = g; in_o = o; in_c_prev = c;
        in_last  = (drv_cnt == 1) ^ bad;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin n_cmp++; n_fail++; $display("FAIL send timeout: got no in_ready want in_ready"); end
        drv_cnt  = (drv_cnt + 1) % 2;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] ec, input logic [31:0] eh);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk({nm, " valid"}, out_valid, 1);
        chk({nm, " c"}, out_c, sp(ec));
        chk({nm, " h"}, out_h, sp(eh));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " one-cycle valid"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) begin @(posedge clk); #1; end
        chk("drain queue", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
        in_f = '0; in_g = '0; in_i = '0; in_o = '0; in_c_prev = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_c", out_c, 0);
        chk("rst out_h", out_h, 0);
        chk("rst out_last", out_last, 0);
        chk("rst seq_err", seq_err, 0);
        chk("rst in_ready", in_ready, 1);
        @(posedge clk); #1;

        // pin the model on hand-computed values
        chk("model basic c", model_c(0, 32'h0008_0000, 32'h0000_8000, 32'h0002_0000), 32'h0001_8000);
        chk("model basic h", model_h(32'h0008_0000, 32'h0001_8000), 32'h0001_0000);
        chk("model sat c", model_c(32'h0008_0000, 32'h0008_0000, 32'h0001_0000, 32'h7FFF_0000), 32'h7FFF_FFFF);
        chk("model neg c", model_c(32'h0008_0000, 32'h0008_0000, 32'hFFFF_0000, 32'h8000_0000), 32'h8000_0000);
        chk("model neg h", model_h(32'h0008_0000, 32'h8000_0000), 32'hFFFF_0000);

        // directed beats with literal expectations (args: f, i, g, o, c_prev)
        send_beat(sp(0), sp(32'h0008_0000), sp(32'h0000_8000), sp(32'h0008_0000), sp(32'h0002_0000), 0);
        lit("basic", 32'h0001_8000, 32'h0001_0000);
        send_beat(sp(32'h0008_0000), sp(32'h0008_0000), sp(32'h0001_0000), sp(32'h0008_0000), sp(32'h7FFF_0000), 0);
        lit("sat pos", 32'h7FFF_FFFF, 32'h0001_0000);
        send_beat(sp(32'h0008_0000), sp(32'h0008_0000), sp(32'hFFFF_0000), sp(32'h0008_0000), sp(32'h8000_0000), 0);
        lit("sat neg", 32'h8000_0000, 32'hFFFF_0000);
        send_beat(rv(), rv(), rv(), rv(), rv(), 0);
        drain();

        // backpressure: 10 beats, out_ready low on cycles 6-9
        fork
            begin
                for (int b = 0; b < 10; b++) send_beat(rv(), rv(), rv(), rv(), rv(), 0);
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    out_ready = !(k >= 6 && k <= 9);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // framing: 6 back-to-back beats -> 3 out_last pulses
        n_last = 0;
        for (int b = 0; b < 6; b++) send_beat(rv(), rv(), rv(), rv(), rv(), 0);
        drain();
        chk("framing out_last count", n_last, 3);

        // random traffic with random backpressure and input gaps
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 60; b++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_beat(rv(), rv(), rv(), rv(), rv(), 0);
                end
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 2000 && !done; k++) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // framing error: in_last on the first beat of a vector
        send_beat(rv(), rv(), rv(), rv(), rv(), 1);
        send_beat(rv(), rv(), rv(), rv(), rv(), 0);
        drain();
        @(negedge clk);
        chk("seq_err sticky", seq_err, 1);
        @(posedge clk); #1;

        // reset with 3 beats in flight
        for (int b = 0; b < 3; b++) send_beat(rv(), rv(), rv(), rv(), rv(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drv_cnt = 0;
        @(negedge clk);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_c", out_c, 0);
        chk("mid rst out_h", out_h, 0);
        chk("mid rst seq_err", seq_err, 0);
        @(posedge clk); #1;
        n_last = 0;
        for (int b = 0; b < 4; b++) send_beat(rv(), rv(), rv(), rv(), rv(), 0);
        drain();
        chk("post rst out_last count", n_last, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_cell_update_pipe.md
# lstm_cell_update_pipe

Parametrised, pipelined successor to the combinational LSTM gate/cell-update stage. It takes pre-activation f/g/i/o gate values and the previous cell state for LANES hidden elements per beat, and streams out c_next and h_t for those elements. A full hidden vector of HIDDEN elements is processed serially over HIDDEN/LANES beats, with valid/ready handshakes on both sides. It sits between the gate matrix-vector unit and the cell-state/hidden-state buffers.

## Interface
- HIDDEN, 100: hidden vector length; must be a multiple of LANES.
- LANES, 4: elements processed per beat.
- DATA_W, 32: signed fixed-point word width.
- FRAC, 16: fractional bits (Q(DATA_W-FRAC).FRAC); 1.0 = 1<<FRAC.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_f, in_g, in_i, in_o  in  LANES x DATA_W signed  gate pre-activations.
- in_c_prev  in  LANES x DATA_W signed  previous cell state.
- in_last  in  1  marks the last beat of a hidden vector.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_c  out  LANES x DATA_W signed  c_next.
- out_h  out  LANES x DATA_W signed  h_t.
- out_last  out  1  last beat of a vector; generated internally.
- seq_err  out  1  sticky flag: in_last disagreed with the internal beat count.

## Operation
- Activations are piecewise linear, all in Q format:
  - hsig(x) = clamp((x >>> 2) + 0.5, 0, 1.0); applied to f, i and o.
  - htanh(x) = clamp(x, -1.0, 1.0); applied to g and to c_next.
- Multiply: full 2·DATA_W signed product, arithmetic shift right by FRAC (floor), then saturate to DATA_W.
- Add: saturating signed add, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Per lane: c = sat(f'·c_prev + i'·g'); h = o'·htanh(c).
- Beat counter (0..HIDDEN/LANES-1):
  - Increments on each accepted beat and wraps to 0 after the last index.
  - The beat at the last index carries last = 1 through the pipeline to out_last.
- Sequence check: an accepted beat whose in_last differs from (counter == last index) sets seq_err. seq_err stays set until rst; data processing is unaffected.
- Reset, including mid-vector:
  - All stage valids, the counter and seq_err clear to 0.
  - out_c, out_h and out_last reset to 0; out_valid resets to 0.
  - In-flight beats are discarded.

## Timing
- Four-stage pipeline; latency is 4 cycles from input acceptance to out_valid when unstalled.
  - S1: activations.
  - S2: both products.
  - S3: saturating add, register c, htanh(c).
  - S4: o'·htanh(c), registered onto out_h. out_c is carried alongside.
- Throughput is 1 beat/cycle, i.e. HIDDEN/LANES cycles per vector.
- Stall is global: stall = out_valid && !out_ready; in_ready = !stall.
  - When stalled, every stage register holds.
- Outputs stay stable while out_valid && !out_ready.
- in_ready has a combinational path from out_ready. No combinational path from in_* to out_*.
- A new vector may begin on the cycle after the previous last beat is accepted; no bubble is required.

## Structure
- Shared package lstm_pkg:
  - Typedef for the Q word.
  - Constants ONE = 1<<FRAC, HALF, DATA_MAX and DATA_MIN.
  - Functions sat_mul_q and sat_add_q.
- One sub-module, lstm_act_pwl: combinational, with a mode input selecting sigmoid or tanh and DATA_W/FRAC parameters. It is instantiated per lane and per gate in S1, and per lane in S3.
- Elaboration check: HIDDEN % LANES == 0.

## Test plan
All values in Q16.16 (1.0 = 0x00010000); LANES=4 unless stated.
- Basic, all lanes: f=0, i=8.0, g=0.5, o=8.0, c_prev=2.0 -> after 4 cycles out_c=0x00018000 (1.5) and out_h=0x00010000 (1.0); out_valid for exactly one cycle.
- Saturation: f=8.0, i=8.0, g=1.0, c_prev=0x7FFF0000 -> out_c=0x7FFFFFFF, out_h=0x00010000. Negative mirror: f=8.0, i=8.0, g=-1.0, c_prev=0x80000000 -> out_c=0x80000000, out_h=0xFFFF0000 (-1.0).
- Backpressure: stream 10 beats with out_ready low for cycles 6-9 -> in_ready low exactly while out_valid && !out_ready; no beat lost or duplicated; order preserved.
- Vector framing with HIDDEN=8, LANES=4: 6 back-to-back beats with correct in_last -> out_last on output beats 2, 4 and 6; seq_err stays 0.
- Framing error: in_last=1 on beat 1 of a vector -> seq_err=1 from the next cycle and held; outputs still correct.
- Reset mid-vector: assert rst for 1 cycle with 3 beats in flight -> the next cycle shows out_valid=0, out_c=out_h=0, seq_err=0, and the next accepted beat is treated as beat 0.
